// File: rtl/pma_pkg.sv
// Shared types for the physical-memory-attribute region table and its lookup logic.
package pma_pkg;

    localparam int PMA_ATTR_W = 5;

    typedef struct packed {
        logic lock;
        logic en;
        logic x;
        logic c;
        logic ni;
    } pma_attr_t;

    typedef enum logic [1:0] {
        FIELD_BASE = 2'd0,
        FIELD_LEN  = 2'd1,
        FIELD_ATTR = 2'd2,
        FIELD_RSVD = 2'd3
    } pma_field_e;

endpackage

// File: rtl/pma_region_match.sv
// Combinational priority match of one address against every table entry.
module pma_region_match #(
    parameter int unsigned NrRegions = 8,
    parameter int unsigned AddrWidth = 64
) (
    input  logic [AddrWidth-1:0]                 addr,
    input  logic [NrRegions-1:0][AddrWidth-1:0]  base,
    input  logic [NrRegions-1:0][AddrWidth-1:0]  len,
    input  logic [NrRegions-1:0]                 en,
    input  logic [NrRegions-1:0][2:0]            xcn_tbl,
    output logic                                 hit,
    output logic [2:0]                           xcn
);

    logic [AddrWidth:0] top;

    // Walk from the highest index down so the lowest matching entry is the last writer.
    // The end address carries one extra bit so a region ending at 2^AddrWidth does not wrap.
    always_comb begin
        hit = 1'b0;
        xcn = '0;
        top = '0;
        for (int i = NrRegions - 1; i >= 0; i--) begin
            top = {1'b0, base[i]} + {1'b0, len[i]};
            if (en[i] && (len[i] != '0) && (addr >= base[i]) && ({1'b0, addr} < top)) begin
                hit = 1'b1;
                xcn = xcn_tbl[i];
            end
        end
    end

endmodule

// File: rtl/pma_region_table.sv
// Runtime-programmable PMA region table with a CSR config port and NrPorts lookups.
// Define PMA_TABLE_LKP_PIPE_EN to register lookup results (1-cycle latency); default is combinational.
module pma_region_table
    import pma_pkg::*;
#(
    parameter int unsigned                        NrRegions = 8,
    parameter int unsigned                        AddrWidth = 64,
    parameter int unsigned                        NrPorts   = 2,
    parameter logic [NrRegions*AddrWidth-1:0]     RstBase   = '0,
    parameter logic [NrRegions*AddrWidth-1:0]     RstLen    = '0,
    parameter logic [NrRegions*PMA_ATTR_W-1:0]    RstAttr   = '0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         cfg_req_i,
    input  logic                         cfg_we_i,
    input  logic [3:0]                   cfg_idx_i,
    input  logic [1:0]                   cfg_field_i,
    input  logic [AddrWidth-1:0]         cfg_wdata_i,
    output logic                         cfg_gnt_o,
    output logic                         cfg_rvalid_o,
    output logic [AddrWidth-1:0]         cfg_rdata_o,
    output logic                         cfg_err_o,
    output logic [7:0]                   cfg_gen_o,
    input  logic [NrPorts-1:0]           lkp_valid_i,
    input  logic [NrPorts*AddrWidth-1:0] lkp_addr_i,
    output logic [NrPorts-1:0]           lkp_valid_o,
    output logic [NrPorts-1:0]           lkp_hit_o,
    output logic [NrPorts*3-1:0]         lkp_attr_o
);

    logic [NrRegions-1:0][AddrWidth-1:0] base_q, len_q;
    pma_attr_t [NrRegions-1:0]           attr_q;
    logic [NrRegions-1:0]                ent_en;
    logic [NrRegions-1:0][2:0]           ent_xcn;

    logic                 rvalid_q, err_q;
    logic [AddrWidth-1:0] rdata_q;
    logic [7:0]           gen_q;

    pma_field_e           field;
    logic                 idx_ok, field_ok, wr_ok, err_d;
    logic [AddrWidth-1:0] sel_base, sel_len, rd_val, rdata_d;
    pma_attr_t            sel_attr;

    assign field    = pma_field_e'(cfg_field_i);
    assign idx_ok   = 32'(cfg_idx_i) < NrRegions;
    assign field_ok = field != FIELD_RSVD;

    // Out-of-range indices select nothing, so sel_attr.lock is 0 and the idx check alone flags them.
    always_comb begin
        sel_base = '0;
        sel_len  = '0;
        sel_attr = '0;
        for (int i = 0; i < NrRegions; i++) begin
            if (cfg_idx_i == 4'(i)) begin
                sel_base = base_q[i];
                sel_len  = len_q[i];
                sel_attr = attr_q[i];
            end
        end
    end

    always_comb begin
        rd_val = '0;
        case (field)
            FIELD_BASE: rd_val = sel_base;
            FIELD_LEN:  rd_val = sel_len;
            FIELD_ATTR: rd_val[PMA_ATTR_W-1:0] = sel_attr;
            default:    rd_val = '0;
        endcase
    end

    assign wr_ok   = cfg_req_i & cfg_we_i & idx_ok & field_ok & ~sel_attr.lock;
    assign err_d   = cfg_req_i & (~idx_ok | ~field_ok | (cfg_we_i & sel_attr.lock));
    assign rdata_d = (cfg_req_i & ~cfg_we_i & idx_ok & field_ok) ? rd_val : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NrRegions; i++) begin
                base_q[i] <= RstBase[i*AddrWidth +: AddrWidth];
                len_q[i]  <= RstLen[i*AddrWidth +: AddrWidth];
                attr_q[i] <= pma_attr_t'(RstAttr[i*PMA_ATTR_W +: PMA_ATTR_W]);
            end
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            gen_q    <= '0;
        end else begin
            rvalid_q <= cfg_req_i;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            if (wr_ok) begin
                gen_q <= gen_q + 8'd1;
                for (int i = 0; i < NrRegions; i++) begin
                    if (cfg_idx_i == 4'(i)) begin
                        case (field)
                            FIELD_BASE: base_q[i] <= cfg_wdata_i;
                            FIELD_LEN:  len_q[i]  <= cfg_wdata_i;
                            FIELD_ATTR: attr_q[i] <= pma_attr_t'(cfg_wdata_i[PMA_ATTR_W-1:0]);
                            default:    ;
                        endcase
                    end
                end
            end
        end
    end

    assign cfg_gnt_o    = cfg_req_i;
    assign cfg_rvalid_o = rvalid_q;
    assign cfg_err_o    = err_q;
    assign cfg_rdata_o  = rdata_q;
    assign cfg_gen_o    = gen_q;

    always_comb begin
        ent_en  = '0;
        ent_xcn = '0;
        for (int i = 0; i < NrRegions; i++) begin
            ent_en[i]  = attr_q[i].en;
            ent_xcn[i] = {attr_q[i].x, attr_q[i].c, attr_q[i].ni};
        end
    end

    logic [NrPorts-1:0]      hit;
    logic [NrPorts-1:0][2:0] xcn;

    for (genvar p = 0; p < NrPorts; p++) begin : g_port
        pma_region_match #(
            .NrRegions (NrRegions),
            .AddrWidth (AddrWidth)
        ) u_match (
            .addr    (lkp_addr_i[p*AddrWidth +: AddrWidth]),
            .base    (base_q),
            .len     (len_q),
            .en      (ent_en),
            .xcn_tbl (ent_xcn),
            .hit     (hit[p]),
            .xcn     (xcn[p])
        );
    end

`ifdef PMA_TABLE_LKP_PIPE_EN
    logic [NrPorts-1:0]      lkp_vld_q, lkp_hit_q;
    logic [NrPorts-1:0][2:0] lkp_xcn_q;

    // Results hold while a port is idle; only the valid bit tracks every cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lkp_vld_q <= '0;
            lkp_hit_q <= '0;
            lkp_xcn_q <= '0;
        end else begin
            lkp_vld_q <= lkp_valid_i;
            for (int p = 0; p < NrPorts; p++) begin
                if (lkp_valid_i[p]) begin
                    lkp_hit_q[p] <= hit[p];
                    lkp_xcn_q[p] <= xcn[p];
                end
            end
        end
    end

    assign lkp_valid_o = lkp_vld_q;
    assign lkp_hit_o   = lkp_hit_q;
    assign lkp_attr_o  = lkp_xcn_q;
`else
    assign lkp_valid_o = lkp_valid_i;
    assign lkp_hit_o   = hit;
    assign lkp_attr_o  = xcn;
`endif

endmodule

// File: tb/tb_pma_region_table.sv
// Self-checking bench for pma_region_table: directed checks plus randomized traffic against a table model.
module tb_pma_region_table;

    localparam logic [8*64-1:0] RB = {448'b0, 64'h8000_0000};
    localparam logic [8*64-1:0] RL = {448'b0, 64'h4000_0000};
    localparam logic [8*5-1:0]  RA = {35'b0, 5'b01110};

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cfg_req = 1'b0, cfg_we = 1'b0;
    logic [3:0]       cfg_idx = '0;
    logic [1:0]       cfg_field = '0;
    logic [63:0]      cfg_wdata = '0;
    logic [1:0]       lkp_valid = '0;
    logic [1:0][63:0] lkp_addr = '0;

    logic             cfg_gnt_o, cfg_rvalid_o, cfg_err_o;
    logic [63:0]      cfg_rdata_o;
    logic [7:0]       cfg_gen_o;
    logic [1:0]       lkp_valid_o, lkp_hit_o;
    logic [5:0]       lkp_attr_o;

    pma_region_table #(
        .NrRegions (8),
        .AddrWidth (64),
        .NrPorts   (2),
        .RstBase   (RB),
        .RstLen    (RL),
        .RstAttr   (RA)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cfg_req_i    (cfg_req),
        .cfg_we_i     (cfg_we),
        .cfg_idx_i    (cfg_idx),
        .cfg_field_i  (cfg_field),
        .cfg_wdata_i  (cfg_wdata),
        .cfg_gnt_o    (cfg_gnt_o),
        .cfg_rvalid_o (cfg_rvalid_o),
        .cfg_rdata_o  (cfg_rdata_o),
        .cfg_err_o    (cfg_err_o),
        .cfg_gen_o    (cfg_gen_o),
        .lkp_valid_i  (lkp_valid),
        .lkp_addr_i   (lkp_addr),
        .lkp_valid_o  (lkp_valid_o),
        .lkp_hit_o    (lkp_hit_o),
        .lkp_attr_o   (lkp_attr_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Table model: plain arrays updated with the config rules.
    logic [63:0] m_base [8];
    logic [63:0] m_len  [8];
    logic [4:0]  m_attr [8];
    logic [7:0]  m_gen;
    logic        e_rvalid, e_err;
    logic [63:0] e_rdata;
    logic [1:0]  e_lv, e_hit;
    logic [1:0][2:0] e_attr;
    bit          armed = 0;

    function automatic logic [3:0] ref_lookup(input logic [63:0] a);
        for (int i = 0; i < 8; i++)
            if (m_attr[i][3] && m_len[i] != 0 && a >= m_base[i] && (a - m_base[i]) < m_len[i])
                return {1'b1, m_attr[i][2:0]};
        return 4'b0;
    endfunction

    always @(posedge clk) begin
        logic ok;
        logic [3:0] r;
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                m_base[i] = RB[i*64 +: 64];
                m_len[i]  = RL[i*64 +: 64];
                m_attr[i] = RA[i*5 +: 5];
            end
            m_gen = 0; e_rvalid = 0; e_err = 0; e_rdata = 0;
            e_lv = 0; e_hit = 0; e_attr = 0;
            armed = 1;
        end else begin
            e_lv = lkp_valid;
            for (int p = 0; p < 2; p++) begin
                if (lkp_valid[p]) begin
                    r = ref_lookup(lkp_addr[p]);
                    e_hit[p]  = r[3];
                    e_attr[p] = r[2:0];
                end
            end
            e_rvalid = cfg_req; e_err = 0; e_rdata = 0;
            if (cfg_req) begin
                ok = (cfg_idx < 8) && (cfg_field != 3);
                if (cfg_we) begin
                    if (ok) ok = !m_attr[cfg_idx[2:0]][4];
                    e_err = !ok;
                    if (ok) begin
                        case (cfg_field)
                            2'd0: m_base[cfg_idx[2:0]] = cfg_wdata;
                            2'd1: m_len[cfg_idx[2:0]]  = cfg_wdata;
                            default: m_attr[cfg_idx[2:0]] = cfg_wdata[4:0];
                        endcase
                        m_gen = m_gen + 1;
                    end
                end else begin
                    e_err = !ok;
                    if (ok)
                        e_rdata = (cfg_field == 0) ? m_base[cfg_idx[2:0]] :
                                  (cfg_field == 1) ? m_len[cfg_idx[2:0]]  : {59'b0, m_attr[cfg_idx[2:0]]};
                end
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        logic [3:0] r;
        if (armed) begin
            chk("gnt", cfg_gnt_o, cfg_req);
            chk("rvalid", cfg_rvalid_o, e_rvalid);
            if (e_rvalid) begin
                chk("err", cfg_err_o, e_err);
                chk("rdata", cfg_rdata_o, e_rdata);
            end
            chk("gen", cfg_gen_o, m_gen);
            for (int p = 0; p < 2; p++) begin
`ifdef PMA_TABLE_LKP_PIPE_EN
                chk("lkp_valid", lkp_valid_o[p], e_lv[p]);
                chk("lkp_hit", lkp_hit_o[p], e_hit[p]);
                chk("lkp_attr", lkp_attr_o[p*3 +: 3], e_attr[p]);
`else
                chk("lkp_valid", lkp_valid_o[p], lkp_valid[p]);
                if (lkp_valid[p]) begin
                    r = ref_lookup(lkp_addr[p]);
                    chk("lkp_hit", lkp_hit_o[p], r[3]);
                    chk("lkp_attr", lkp_attr_o[p*3 +: 3], r[2:0]);
                end
`endif
            end
        end
    end

    task automatic cyc(); @(posedge clk); #1; endtask
    task automatic mid(); @(negedge clk); #1; endtask

    // All directed tasks start and end just after a rising edge.
    task automatic cfg_acc(input logic we, input logic [3:0] idx, input logic [1:0] fld,
                           input logic [63:0] wd, output logic err, output logic [63:0] rd,
                           output logic [7:0] gen);
        cfg_req = 1; cfg_we = we; cfg_idx = idx; cfg_field = fld; cfg_wdata = wd;
        cyc();
        cfg_req = 0;
        mid();
        err = cfg_err_o; rd = cfg_rdata_o; gen = cfg_gen_o;
        cyc();
    endtask

    task automatic lkp(input int p, input logic [63:0] a, output logic h, output logic [2:0] at);
        lkp_valid[p] = 1; lkp_addr[p] = a;
`ifdef PMA_TABLE_LKP_PIPE_EN
        cyc();
        lkp_valid[p] = 0;
        mid();
        h = lkp_hit_o[p]; at = lkp_attr_o[p*3 +: 3];
        cyc();
`else
        mid();
        h = lkp_hit_o[p]; at = lkp_attr_o[p*3 +: 3];
        cyc();
        lkp_valid[p] = 0;
`endif
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        logic        h, err;
        logic [2:0]  at;
        logic [63:0] rd, a;
        logic [7:0]  gen;
        int          j;

        repeat (3) cyc();
        mid();
        chk("reset rvalid", cfg_rvalid_o, 0);
        chk("reset err", cfg_err_o, 0);
        chk("reset rdata", cfg_rdata_o, 0);
        chk("reset gen", cfg_gen_o, 0);
        chk("reset lkp_valid", lkp_valid_o, 0);
        chk("reset lkp_hit", lkp_hit_o, 0);
        chk("reset lkp_attr", lkp_attr_o, 0);
        cyc();
        rst = 0;

        lkp(0, 64'h8000_1000, h, at);
        chk("rstval hit", h, 1);
        chk("rstval attr", at, 3'b110);
        lkp(1, 64'hC000_0000, h, at);
        chk("rstval end hit", h, 0);
        chk("rstval end attr", at, 0);

        // Same-cycle write (entry 0 disabled) and lookup.
        cfg_req = 1; cfg_we = 1; cfg_idx = 0; cfg_field = 2; cfg_wdata = 64'h06;
        lkp_valid[0] = 1; lkp_addr[0] = 64'h8000_1000;
`ifdef PMA_TABLE_LKP_PIPE_EN
        cyc(); cfg_req = 0;
        mid(); chk("same-cycle hit N", lkp_hit_o[0], 1);
        cyc(); lkp_valid[0] = 0;
        mid(); chk("same-cycle hit N+1", lkp_hit_o[0], 0);
        cyc();
`else
        mid(); chk("same-cycle hit N", lkp_hit_o[0], 1);
        cyc(); cfg_req = 0;
        mid(); chk("same-cycle hit N+1", lkp_hit_o[0], 0);
        cyc(); lkp_valid[0] = 0;
`endif

        cfg_acc(1, 1, 0, 64'h8000_0000, err, rd, gen);
        cfg_acc(1, 1, 1, 64'h1000, err, rd, gen);
        cfg_acc(1, 1, 2, 64'h09, err, rd, gen);
        cfg_acc(1, 2, 0, 64'h8000_0000, err, rd, gen);
        cfg_acc(1, 2, 1, 64'h1000, err, rd, gen);
        cfg_acc(1, 2, 2, 64'h0E, err, rd, gen);
        chk("gen after 7 writes", gen, 8'd7);
        lkp(1, 64'h8000_0800, h, at);
        chk("overlap hit", h, 1);
        chk("overlap attr", at, 3'b001);

        cfg_acc(1, 3, 2, 64'h1E, err, rd, gen);
        chk("lock write err", err, 0);
        cfg_acc(1, 3, 0, 64'h1000, err, rd, gen);
        chk("locked write err", err, 1);
        chk("locked write gen", gen, 8'd8);
        cfg_acc(0, 3, 0, 0, err, rd, gen);
        chk("locked base readback", rd, 64'h0);
        cfg_acc(0, 3, 2, 0, err, rd, gen);
        chk("locked attr read err", err, 0);
        chk("locked attr readback", rd, 64'h1E);

        cfg_acc(1, 4, 0, 64'hFFFF_FFFF_FFFF_F000, err, rd, gen);
        cfg_acc(1, 4, 1, 64'h1000, err, rd, gen);
        cfg_acc(1, 4, 2, 64'h0C, err, rd, gen);
        cfg_acc(1, 5, 2, 64'h0F, err, rd, gen);
        lkp(0, 64'hFFFF_FFFF_FFFF_FFFF, h, at);
        chk("top hit", h, 1);
        chk("top attr", at, 3'b100);
        lkp(1, 64'hFFFF_FFFF_FFFF_EFFF, h, at);
        chk("below top hit", h, 0);
        lkp(0, 64'h0, h, at);
        chk("len0 hit", h, 0);

        cfg_acc(0, 15, 0, 0, err, rd, gen);
        chk("oob read err", err, 1);
        chk("oob read rdata", rd, 0);
        cfg_acc(0, 2, 3, 0, err, rd, gen);
        chk("rsvd read err", err, 1);
        cfg_acc(1, 15, 2, 64'h1F, err, rd, gen);
        chk("oob write err", err, 1);

        // Generation counter wrap from a fresh reset.
        rst = 1; cyc(); cyc(); rst = 0;
        cfg_req = 1; cfg_we = 1; cfg_idx = 5; cfg_field = 0;
        for (int i = 0; i < 255; i++) begin
            cfg_wdata = 64'(i) << 12;
            cyc();
        end
        cfg_req = 0;
        mid(); chk("gen 255", cfg_gen_o, 8'd255);
        cyc();
        cfg_acc(1, 5, 1, 64'h100, err, rd, gen);
        chk("gen wrap", gen, 8'd0);

        // Randomized traffic, with one reset in the middle.
        for (int c = 0; c < 3000; c++) begin
            rst = (c == 1500);
            cfg_req = ($urandom_range(0, 9) < 4);
            cfg_we = ($urandom_range(0, 2) != 0);
            cfg_idx = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
            cfg_field = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            case (cfg_field)
                2'd0: cfg_wdata = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_F000_0000
                                                               : 64'($urandom_range(0, 15)) << 28;
                2'd1: case ($urandom_range(0, 4))
                        0: cfg_wdata = 0;
                        1: cfg_wdata = 64'h1000;
                        2: cfg_wdata = 64'h1000_0000;
                        3: cfg_wdata = 64'h4000_0000;
                        default: cfg_wdata = 64'($urandom_range(1, 8)) << 28;
                      endcase
                default: cfg_wdata = {59'b0, ($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                                      3'($urandom_range(0, 7))};
            endcase
            for (int p = 0; p < 2; p++) begin
                lkp_valid[p] = ($urandom_range(0, 3) != 0);
                j = $urandom_range(0, 7);
                case ($urandom_range(0, 5))
                    0: a = m_base[j] - 1;
                    1: a = m_base[j];
                    2: a = m_base[j] + m_len[j] - 1;
                    3: a = m_base[j] + m_len[j];
                    4: a = m_base[j] + (rnd64() % ((m_len[j] != 0) ? m_len[j] : 64'd1));
                    default: a = rnd64();
                endcase
                lkp_addr[p] = a;
            end
            cyc();
        end
        rst = 0; cfg_req = 0; lkp_valid = 0;
        cyc(); cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
